// File: rtl/instr_mem_arbiter_if.sv
// Bundles the core-side and memory-side signals of the two-core instruction fetch arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface instr_mem_arbiter_if;
    logic [1:0]       core_req_i;
    logic [1:0][31:0] core_addr_i;
    logic [1:0]       core_gnt_o;
    logic [1:0]       core_rvalid_o;
    logic [31:0]      core_rdata_o;
    logic             core_err_o;
    logic             mem_req_o;
    logic             mem_gnt_i;
    logic [31:0]      mem_addr_o;
    logic             mem_rvalid_i;
    logic [31:0]      mem_rdata_i;
    logic             mem_err_i;
    logic [2:0]       outstanding_o;
    logic             spurious_o;

    modport slave (
        input  core_req_i, core_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o, mem_req_o, mem_addr_o,
        output outstanding_o, spurious_o
    );

    modport master (
        output core_req_i, core_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o, mem_req_o, mem_addr_o,
        input  outstanding_o, spurious_o
    );
endinterface

// File: rtl/instr_mem_arbiter.sv
// Round-robin arbiter sharing one instruction memory port between two cores, with an
// in-order ID FIFO that steers each memory response back to the core that issued it.
module instr_mem_arbiter #(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    instr_mem_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {StFree, StLocked} lock_state_e;

    lock_state_e state_q, state_d;
    logic        lock_id_q, lock_id_d;
    logic        ptr_q, ptr_d;
    logic [3:0]  fifo_q, fifo_d;
    logic [1:0]  wr_q, wr_d;
    logic [1:0]  rd_q, rd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        spur_q, spur_d;

    logic sel;
    logic mem_req;
    logic hs;
    logic pop;
    logic head;

    function automatic logic [1:0] inc_ptr(input logic [1:0] p);
        return (p == 2'(OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // A pending unacknowledged request keeps its core selected until the handshake.
    always_comb begin
        sel = ptr_q;
        if (state_q == StLocked) begin
            sel = lock_id_q;
        end else begin
            unique case (bus.core_req_i)
                2'b01:   sel = 1'b0;
                2'b10:   sel = 1'b1;
                default: sel = ptr_q;
            endcase
        end
    end

    always_comb begin
        mem_req = rst_ni & bus.core_req_i[sel] & (cnt_q < 3'(OUTSTANDING));
        hs      = mem_req & bus.mem_gnt_i;
        pop     = rst_ni & bus.mem_rvalid_i & (cnt_q != 3'd0);
        head    = fifo_q[rd_q];

        bus.mem_req_o     = mem_req;
        bus.mem_addr_o    = mem_req ? bus.core_addr_i[sel] : 32'd0;
        bus.core_gnt_o    = hs ? (sel ? 2'b10 : 2'b01) : 2'b00;
        bus.core_rvalid_o = pop ? (head ? 2'b10 : 2'b01) : 2'b00;
        bus.core_rdata_o  = bus.mem_rdata_i;
        bus.core_err_o    = bus.mem_err_i;
        bus.outstanding_o = cnt_q;
        bus.spurious_o    = spur_q;
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        ptr_d     = ptr_q;
        if (hs) begin
            state_d = StFree;
            ptr_d   = ~sel;
        end else if (mem_req) begin
            state_d   = StLocked;
            lock_id_d = sel;
        end
    end

    always_comb begin
        fifo_d = fifo_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q + {2'b00, hs} - {2'b00, pop};
        spur_d = spur_q | (bus.mem_rvalid_i & (cnt_q == 3'd0));
        if (hs) begin
            fifo_d[wr_q] = sel;
            wr_d         = inc_ptr(wr_q);
        end
        if (pop) begin
            rd_d = inc_ptr(rd_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StFree;
            lock_id_q <= 1'b0;
            ptr_q     <= 1'b0;
            fifo_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            spur_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            ptr_q     <= ptr_d;
            fifo_q    <= fifo_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            spur_q    <= spur_d;
        end
    end

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed, table-driven bench for instr_mem_arbiter with OUTSTANDING=2 plus a lock sequence.
module tb_instr_mem_arbiter;

    logic clk;
    logic rst_ni;
    int   n_checks;
    int   n_fail;

    instr_mem_arbiter_if bus ();

    instr_mem_arbiter #(.OUTSTANDING(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
        logic        e_mreq;
        logic [31:0] e_addr;
        logic [2:0]  e_out;
        logic        e_spur;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [1:0] req, logic [31:0] a0, logic [31:0] a1,
                                logic gnt, logic rv, logic [31:0] rdata, logic err,
                                logic [1:0] e_gnt, logic [1:0] e_rv, logic e_mreq,
                                logic [31:0] e_addr, logic [2:0] e_out, logic e_spur);
        vec_t v;
        v.rst = rst; v.req = req; v.a0 = a0; v.a1 = a1; v.gnt = gnt; v.rv = rv;
        v.rdata = rdata; v.err = err; v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_mreq = e_mreq;
        v.e_addr = e_addr; v.e_out = e_out; v.e_spur = e_spur;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                         input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic err);
        bus.core_req_i     = req;
        bus.core_addr_i[0] = a0;
        bus.core_addr_i[1] = a1;
        bus.mem_gnt_i      = gnt;
        bus.mem_rvalid_i   = rv;
        bus.mem_rdata_i    = rdata;
        bus.mem_err_i      = err;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_ni   = 1'b0;
        drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);

        // rst req a0 a1 gnt rv rdata err | gnt rv mreq addr out spur
        vecs.push_back(mk(0, 2'b01, 32'h1000, 0, 1, 0, 0, 0, 2'b01, 2'b00, 1, 32'h1000, 0, 0));
        vecs.push_back(mk(0, 2'b00, 32'h1000, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0));
        vecs.push_back(mk(0, 2'b00, 32'h1000, 0, 0, 1, 32'hDEADBEEF, 0, 2'b00, 2'b01, 0, 0, 1, 0));
        vecs.push_back(mk(0, 2'b00, 32'h1000, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'b11, 32'hA0, 32'hB0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b11, 32'hA0, 32'hB0, 1, 0, 0, 0, 2'b01, 2'b00, 1, 32'hA0, 0, 0));
        vecs.push_back(mk(0, 2'b11, 32'hA0, 32'hB0, 1, 1, 32'h11, 0, 2'b10, 2'b01, 1, 32'hB0, 1, 0));
        vecs.push_back(mk(0, 2'b11, 32'hA0, 32'hB0, 1, 1, 32'h22, 0, 2'b01, 2'b10, 1, 32'hA0, 1, 0));
        vecs.push_back(mk(0, 2'b11, 32'hA0, 32'hB0, 0, 1, 32'h33, 1, 2'b00, 2'b01, 1, 32'hB0, 1, 0));
        vecs.push_back(mk(0, 2'b11, 32'hA0, 32'hB0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 32'hB0, 0, 0));
        vecs.push_back(mk(0, 2'b11, 32'hA0, 32'hB0, 1, 0, 0, 0, 2'b10, 2'b00, 1, 32'hB0, 0, 0));
        vecs.push_back(mk(0, 2'b11, 32'hA0, 32'hB0, 1, 0, 0, 0, 2'b01, 2'b00, 1, 32'hA0, 1, 0));
        vecs.push_back(mk(0, 2'b11, 32'hA0, 32'hB0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2, 0));
        vecs.push_back(mk(0, 2'b11, 32'hA0, 32'hB0, 1, 1, 32'h44, 0, 2'b00, 2'b10, 0, 0, 2, 0));
        vecs.push_back(mk(0, 2'b11, 32'hA0, 32'hB0, 1, 1, 32'h55, 0, 2'b10, 2'b01, 1, 32'hB0, 1, 0));
        vecs.push_back(mk(0, 2'b11, 32'hA0, 32'hB0, 1, 0, 0, 0, 2'b01, 2'b00, 1, 32'hA0, 1, 0));
        vecs.push_back(mk(0, 2'b00, 32'hA0, 32'hB0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2, 0));
        vecs.push_back(mk(1, 2'b11, 32'hA0, 32'hB0, 1, 1, 32'h66, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 32'hA0, 32'hB0, 0, 1, 32'h77, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 32'hA0, 32'hB0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1));
        vecs.push_back(mk(0, 2'b01, 32'hA0, 32'hB0, 1, 1, 32'h88, 0, 2'b01, 2'b00, 1, 32'hA0, 0, 1));
        vecs.push_back(mk(0, 2'b00, 32'hA0, 32'hB0, 0, 1, 32'h99, 1, 2'b00, 2'b01, 0, 0, 1, 1));

        // Reset state with reset held low
        #1;
        check("reset mem_req", 32'(bus.mem_req_o), 32'd0);
        check("reset gnt", 32'(bus.core_gnt_o), 32'd0);
        check("reset rvalid", 32'(bus.core_rvalid_o), 32'd0);
        check("reset outstanding", 32'(bus.outstanding_o), 32'd0);
        check("reset spurious", 32'(bus.spurious_o), 32'd0);
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_ni = ~vecs[i].rst;
            drive(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].gnt, vecs[i].rv,
                  vecs[i].rdata, vecs[i].err);
            #1;
            check($sformatf("v%0d gnt", i), 32'(bus.core_gnt_o), 32'(vecs[i].e_gnt));
            check($sformatf("v%0d rvalid", i), 32'(bus.core_rvalid_o), 32'(vecs[i].e_rv));
            check($sformatf("v%0d mem_req", i), 32'(bus.mem_req_o), 32'(vecs[i].e_mreq));
            check($sformatf("v%0d mem_addr", i), bus.mem_addr_o, vecs[i].e_addr);
            check($sformatf("v%0d outstanding", i), 32'(bus.outstanding_o), 32'(vecs[i].e_out));
            check($sformatf("v%0d spurious", i), 32'(bus.spurious_o), 32'(vecs[i].e_spur));
            if (vecs[i].e_rv != 2'b00) begin
                check($sformatf("v%0d rdata", i), bus.core_rdata_o, vecs[i].rdata);
                check($sformatf("v%0d err", i), 32'(bus.core_err_o), 32'(vecs[i].err));
            end
        end

        // Lock: core 1 stalled on 0x2000 while core 0 joins; selection must not switch
        @(negedge clk);
        rst_ni = 1'b0;
        drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            drive((c == 1) ? 2'b10 : 2'b11, 32'h3000, 32'h2000, (c >= 4), 1'b0, 32'd0, 1'b0);
            #1;
            check($sformatf("lock c%0d mem_req", c), 32'(bus.mem_req_o), 32'd1);
            check($sformatf("lock c%0d mem_addr", c), bus.mem_addr_o,
                  (c == 5) ? 32'h3000 : 32'h2000);
            check($sformatf("lock c%0d gnt", c), 32'(bus.core_gnt_o),
                  (c == 4) ? 32'd2 : ((c == 5) ? 32'd1 : 32'd0));
        end

        @(negedge clk);
        drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_arbiter.md
INSTR_MEM_ARBITER -- requirements
Module: instr_mem_arbiter

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2, the maximum number of granted-but-unanswered memory transactions (legal range 1..4).
REQ-002 SHALL have ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- core_req_i  in  [1:0]  per-core fetch request.
- core_addr_i  in  [1:0][31:0]  per-core fetch address.
- core_gnt_o  out  [1:0]  per-core grant.
- core_rvalid_o  out  [1:0]  per-core response valid.
- core_rdata_o  out  32  response data, shared by both cores.
- core_err_o  out  1  response error, shared, meaningful only with a core_rvalid_o bit.
- mem_req_o  out  1  request to instruction memory.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  32  memory address.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  32  memory response data.
- mem_err_i  in  1  memory response error.
- outstanding_o  out  3  count of pending transactions.
- spurious_o  out  1  sticky flag: rvalid arrived with nothing pending.

Function
REQ-003 SHALL arbitrate core_req_i between the two cores:
- only one requesting -> that core wins.
- both requesting -> the core named by a round-robin pointer wins.
REQ-004 SHALL move the pointer to the non-winning core on every memory handshake (mem_req_o & mem_gnt_i).
- Pointer SHALL NOT move on cycles without a handshake.
REQ-005 SHALL drive mem_req_o = winner's request & (count < OUTSTANDING), and mem_addr_o = winner's address.
- mem_addr_o SHALL be 0 when mem_req_o is low.
REQ-006 SHALL lock the winner once mem_req_o is high and mem_gnt_i is low.
- While locked, the selection SHALL stay fixed, regardless of the other core or the pointer, until the handshake.
- The lock SHALL clear on the handshake cycle.
REQ-007 SHALL drive core_gnt_o[winner] = mem_gnt_i & mem_req_o in the same cycle (zero added latency).
- The non-winning core's grant SHALL be 0.
REQ-008 SHALL push the winner's ID into an in-order ID FIFO (depth OUTSTANDING) on each handshake.
REQ-009 SHALL route each mem_rvalid_i to the core at the FIFO head and pop the head in that cycle.
- core_rvalid_o[head] = mem_rvalid_i.
- core_rdata_o = mem_rdata_i and core_err_o = mem_err_i, combinationally.
REQ-010 SHALL support push and pop in the same cycle.
- Count is unchanged.
- Pushing when full is prevented by REQ-005; this holds even when a pop occurs in the same cycle.
REQ-011 SHALL handle mem_rvalid_i with an empty FIFO as follows:
- both core_rvalid_o bits stay 0.
- no pop; count stays 0.
- spurious_o is set and held until reset.
REQ-012 SHALL expose the FIFO occupancy on outstanding_o (0..OUTSTANDING).
REQ-013 SHALL NOT drop or reorder responses: response order equals grant order.

Reset
REQ-014 SHALL, while rst_ni is low, immediately force:
- pointer = core 0, lock = 0, FIFO empty, outstanding_o = 0, spurious_o = 0.
- mem_req_o = 0, core_gnt_o = 0, core_rvalid_o = 0.
REQ-015 SHALL discard pending transactions when reset asserts mid-operation.
- Responses arriving after reset release SHALL be treated per REQ-011.

Verification
REQ-016 Single core: core_req_i=01, addr 0x1000, mem_gnt_i=1 the same cycle, rvalid 2 cycles later -> core_gnt_o=01 that cycle; core_rvalid_o=01 with mem_rdata_i; outstanding_o goes 1 then 0.
REQ-017 Contention: both cores request continuously, mem always grants -> grants alternate 01,10,01,10 starting with core 0 after reset; responses route to the matching core in order.
REQ-018 Lock: core 1 alone requests 0x2000, mem_gnt_i=0 for 3 cycles, core 0 raises its request in cycle 2 -> mem_addr_o stays 0x2000 and core 1 receives the grant.
REQ-019 Back-pressure: OUTSTANDING=2, two grants with no rvalid -> mem_req_o=0 with core_req_i high; one rvalid plus a new handshake in the same cycle -> outstanding_o stays 2.
REQ-020 Faults: rvalid with an empty FIFO -> spurious_o=1 and core_rvalid_o=00; reset asserted with 2 pending -> outstanding_o=0 and spurious_o=0 immediately.
